// File: rtl/lsu_controller_pkg.sv
// Shared constants and helpers for the load/store unit controller:
// funct3 codes, FSM encoding, byte-enable patterns and lane helpers.
package lsu_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Anything that is not a byte or halfword code is sized as a word.
  function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_LB, F3_LBU: return BE_BYTE << off;
      F3_LH, F3_LHU: return BE_HALF << off;
      default:       return BE_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return off[0];
      default:       return (off != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_SB:   return {4{wdata[7:0]}};
      F3_SH:   return {2{wdata[15:0]}};
      F3_SW:   return wdata;
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_controller_load_align.sv
// Combinational load datapath: moves the addressed byte/halfword down to
// bit 0 and sign- or zero-extends it according to funct3.
module load_align
  import lsu_controller_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted_s;

  assign shifted_s = rdata_i >> {addr_i, 3'b000};

  // Extension select; undefined codes behave as a full-word load.
  always_comb begin
    result_o = shifted_s;
    case (funct3_i)
      F3_LB:   result_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_LH:   result_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_LBU:  result_o = {24'h000000, shifted_s[7:0]};
      F3_LHU:  result_o = {16'h0000, shifted_s[15:0]};
      F3_LW:   result_o = shifted_s;
      default: result_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Single-outstanding load/store controller: captures a CPU request, drives a
// word-addressed memory bus with lane enables, and reports done/fault pulses.
module lsu_controller
  import lsu_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  output logic        O_ready,
  output logic        O_done,
  output logic [31:0] O_rdata,
  output logic        O_misaligned,
  output logic        O_buserr,
  output logic        O_mem_req,
  output logic        O_mem_we,
  output logic [3:0]  O_mem_be,
  output logic [31:0] O_mem_addr,
  output logic [31:0] O_mem_wdata,
  input  logic        I_mem_ack,
  input  logic [31:0] I_mem_rdata
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, mis_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [31:0] load_result_s;
  logic        accept_s;

  assign accept_s = (state_q == ST_IDLE) && I_req;

  load_align u_load_align (
    .rdata_i  (I_mem_rdata),
    .addr_i   (off_q),
    .funct3_i (funct3_q),
    .result_o (load_result_s)
  );

  // Next state and access-cycle counter; an ack on the last allowed cycle wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (I_req) begin
          if (is_misaligned(I_funct3, I_addr[1:0])) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = 8'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (I_mem_ack) begin
          state_d = ST_RESP;
        end else if (8'(cnt_q + 8'd1) == TIMEOUT_C) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Load result is only updated by a load completing.
  always_comb begin
    rdata_d = rdata_q;
    if ((state_q == ST_ACCESS) && I_mem_ack && !we_q) begin
      rdata_d = load_result_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // FSM, counter and load-result registers.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request capture; bus fields are precomputed so they stay stable until ack.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      mem_be_q    <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else if (accept_s) begin
      we_q        <= I_we;
      mis_q       <= is_misaligned(I_funct3, I_addr[1:0]);
      funct3_q    <= I_funct3;
      off_q       <= I_addr[1:0];
      mem_be_q    <= byte_enables(I_funct3, I_addr[1:0]);
      mem_addr_q  <= {I_addr[31:2], 2'b00};
      mem_wdata_q <= replicate_store(I_funct3, I_wdata);
    end
  end

  assign O_ready      = (state_q == ST_IDLE);
  assign O_done       = (state_q == ST_RESP) || (state_q == ST_FAULT);
  assign O_misaligned = (state_q == ST_FAULT) && mis_q;
  assign O_buserr     = (state_q == ST_FAULT) && !mis_q;
  assign O_rdata      = rdata_q;
  assign O_mem_req    = (state_q == ST_ACCESS);
  assign O_mem_we     = we_q;
  assign O_mem_be     = mem_be_q;
  assign O_mem_addr   = mem_addr_q;
  assign O_mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: default-TIMEOUT instance for the
// datapath scenarios and a TIMEOUT=4 instance for the bus-error scenarios.
module tb_lsu_controller;

  logic        clk, rst_n;
  logic        req, we, req4, mem_ack, mem_ack4;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;

  logic        ready, done, mis, buserr, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        ready4, done4, mis4, buserr4, mem_req4, mem_we4;
  logic [31:0] rdata4, mem_addr4, mem_wdata4;
  logic [3:0]  mem_be4;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_load;

  lsu_controller dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_req(req), .I_we(we), .I_funct3(funct3),
    .I_addr(addr), .I_wdata(wdata), .O_ready(ready), .O_done(done), .O_rdata(rdata),
    .O_misaligned(mis), .O_buserr(buserr), .O_mem_req(mem_req), .O_mem_we(mem_we),
    .O_mem_be(mem_be), .O_mem_addr(mem_addr), .O_mem_wdata(mem_wdata),
    .I_mem_ack(mem_ack), .I_mem_rdata(mem_rdata)
  );

  lsu_controller #(.TIMEOUT(4)) dut_t4 (
    .I_clk(clk), .I_rst_n(rst_n), .I_req(req4), .I_we(we), .I_funct3(funct3),
    .I_addr(addr), .I_wdata(wdata), .O_ready(ready4), .O_done(done4), .O_rdata(rdata4),
    .O_misaligned(mis4), .O_buserr(buserr4), .O_mem_req(mem_req4), .O_mem_we(mem_we4),
    .O_mem_be(mem_be4), .O_mem_addr(mem_addr4), .O_mem_wdata(mem_wdata4),
    .I_mem_ack(mem_ack4), .I_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; req4 = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0;
    wdata = 32'd0; mem_ack = 1'b0; mem_ack4 = 1'b0; mem_rdata = 32'd0;
    #12;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
    vectors++; if ({done, mis, buserr, mem_req, mem_we} !== 5'b00000) begin miscompares++; $display("FAIL reset_flags: got %b want 00000", {done, mis, buserr, mem_req, mem_we}); end
    vectors++; if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {rdata, mem_addr, mem_wdata, mem_be}); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lbu();
    req = 1'b1; we = 1'b0; funct3 = 3'b100; addr = 32'h103; mem_rdata = 32'hAB000000; mem_ack = 1'b1;
    step();
    req = 1'b0;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL lbu_mem_req: got %b want 1", mem_req); end
    vectors++; if (mem_be !== 4'b1000) begin miscompares++; $display("FAIL lbu_be: got %b want 1000", mem_be); end
    vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL lbu_addr: got %h want 00000100", mem_addr); end
    step();
    mem_ack = 1'b0;
    vectors++; if ({done, mem_req} !== 2'b10) begin miscompares++; $display("FAIL lbu_done: got %b want 10", {done, mem_req}); end
    vectors++; if (rdata !== 32'h000000AB) begin miscompares++; $display("FAIL lbu_rdata: got %h want 000000ab", rdata); end
    step();
    vectors++; if ({done, ready} !== 2'b01) begin miscompares++; $display("FAIL lbu_idle: got %b want 01", {done, ready}); end
  endtask

  task automatic test_lh_delayed();
    req = 1'b1; we = 1'b0; funct3 = 3'b001; addr = 32'h202; mem_rdata = 32'h80010000; mem_ack = 1'b0;
    step();
    req = 1'b0; addr = 32'hFFF; funct3 = 3'b000; we = 1'b1;
    vectors++; if (mem_be !== 4'b1100) begin miscompares++; $display("FAIL lh_be: got %b want 1100", mem_be); end
    for (int i = 1; i < 5; i++) begin
      vectors++; if ({mem_req, done, mem_addr} !== {2'b10, 32'h200}) begin miscompares++; $display("FAIL lh_wait%0d: got %b/%h want 10/00000200", i, {mem_req, done}, mem_addr); end
      step();
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL lh_done: got %b want 1", done); end
    vectors++; if (rdata !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh_rdata: got %h want ffff8001", rdata); end
    last_load = 32'hFFFF8001;
    step();
  endtask

  task automatic test_sb();
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h301; wdata = 32'h123456C3; mem_ack = 1'b1; mem_rdata = 32'h55555555;
    step();
    req = 1'b0;
    vectors++; if (mem_wdata !== 32'hC3C3C3C3) begin miscompares++; $display("FAIL sb_wdata: got %h want c3c3c3c3", mem_wdata); end
    vectors++; if ({mem_be, mem_we} !== 5'b00101) begin miscompares++; $display("FAIL sb_be_we: got %b want 00101", {mem_be, mem_we}); end
    step();
    mem_ack = 1'b0;
    vectors++; if ({done, rdata} !== {1'b1, last_load}) begin miscompares++; $display("FAIL sb_rdata: got %b/%h want 1/%h", done, rdata, last_load); end
    step();
  endtask

  task automatic test_mix();
    logic [2:0]  t_f3 [7];
    logic        t_we [7];
    logic [31:0] t_addr [7], t_wd [7], t_rd [7], t_exp_wd [7], t_exp_rd [7];
    logic [3:0]  t_be [7];
    t_f3 = '{3'b000, 3'b101, 3'b010, 3'b001, 3'b010, 3'b000, 3'b011};
    t_we = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    t_addr = '{32'h001, 32'h002, 32'h004, 32'h102, 32'h108, 32'h000, 32'h00C};
    t_wd = '{32'd0, 32'd0, 32'd0, 32'hBEEF1234, 32'hCAFEF00D, 32'd0, 32'd0};
    t_rd = '{32'h00008000, 32'hF00D0000, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0000007F, 32'h13572468};
    t_be = '{4'b0010, 4'b1100, 4'b1111, 4'b1100, 4'b1111, 4'b0001, 4'b1111};
    t_exp_wd = '{32'd0, 32'd0, 32'd0, 32'h12341234, 32'hCAFEF00D, 32'd0, 32'd0};
    t_exp_rd = '{32'hFFFFFF80, 32'h0000F00D, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000007F, 32'h13572468};
    for (int i = 0; i < 7; i++) begin
      req = 1'b1; we = t_we[i]; funct3 = t_f3[i]; addr = t_addr[i]; wdata = t_wd[i];
      mem_rdata = t_rd[i]; mem_ack = 1'b1;
      step();
      req = 1'b0;
      vectors++; if ({mem_req, mem_we, mem_be} !== {1'b1, t_we[i], t_be[i]}) begin miscompares++; $display("FAIL mix%0d_be: got %b want %b", i, {mem_req, mem_we, mem_be}, {1'b1, t_we[i], t_be[i]}); end
      vectors++; if (mem_addr !== {t_addr[i][31:2], 2'b00}) begin miscompares++; $display("FAIL mix%0d_addr: got %h want %h", i, mem_addr, {t_addr[i][31:2], 2'b00}); end
      if (t_we[i]) begin
        vectors++; if (mem_wdata !== t_exp_wd[i]) begin miscompares++; $display("FAIL mix%0d_wdata: got %h want %h", i, mem_wdata, t_exp_wd[i]); end
      end
      step();
      mem_ack = 1'b0;
      vectors++; if ({done, rdata} !== {1'b1, t_exp_rd[i]}) begin miscompares++; $display("FAIL mix%0d_rdata: got %b/%h want 1/%h", i, done, rdata, t_exp_rd[i]); end
      step();
    end
    last_load = 32'h13572468;
  endtask

  task automatic test_misaligned();
    logic [2:0]  t_f3 [3];
    logic [31:0] t_addr [3];
    t_f3 = '{3'b010, 3'b001, 3'b010};
    t_addr = '{32'h402, 32'h101, 32'h403};
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; we = (i == 2); funct3 = t_f3[i]; addr = t_addr[i]; mem_ack = 1'b1;
      step();
      req = 1'b0; mem_ack = 1'b0;
      vectors++; if ({mis, done, buserr, mem_req} !== 4'b1100) begin miscompares++; $display("FAIL mis%0d_pulse: got %b want 1100", i, {mis, done, buserr, mem_req}); end
      step();
      vectors++; if ({mis, done, mem_req, ready, rdata} !== {4'b0001, last_load}) begin miscompares++; $display("FAIL mis%0d_after: got %b/%h want 0001/%h", i, {mis, done, mem_req, ready}, rdata, last_load); end
    end
  endtask

  task automatic test_timeout();
    req4 = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10; mem_ack4 = 1'b0;
    step();
    req4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      vectors++; if ({mem_req4, buserr4, done4} !== 3'b100) begin miscompares++; $display("FAIL to_wait%0d: got %b want 100", i, {mem_req4, buserr4, done4}); end
      step();
    end
    vectors++; if ({buserr4, done4, mis4, mem_req4} !== 4'b1100) begin miscompares++; $display("FAIL to_buserr: got %b want 1100", {buserr4, done4, mis4, mem_req4}); end
    step();
    vectors++; if ({buserr4, done4, ready4} !== 3'b001) begin miscompares++; $display("FAIL to_after: got %b want 001", {buserr4, done4, ready4}); end
    req4 = 1'b1; mem_rdata = 32'h11223344;
    step();
    req4 = 1'b0;
    for (int i = 1; i < 4; i++) step();
    mem_ack4 = 1'b1;
    step();
    mem_ack4 = 1'b0;
    vectors++; if ({done4, buserr4, rdata4} !== {2'b10, 32'h11223344}) begin miscompares++; $display("FAIL to_ack_wins: got %b/%h want 10/11223344", {done4, buserr4}, rdata4); end
    step();
    vectors++; if ({done4, buserr4, ready4} !== 3'b001) begin miscompares++; $display("FAIL to_ack_after: got %b want 001", {done4, buserr4, ready4}); end
  endtask

  task automatic test_reset_mid_access();
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h20; mem_ack = 1'b0;
    step();
    req = 1'b0;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_pre: got %b want 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_async_drop: got %b want 0", mem_req); end
    mem_ack = 1'b1;
    step();
    vectors++; if ({done, ready, rdata} !== {2'b01, 32'd0}) begin miscompares++; $display("FAIL rst_hold: got %b/%h want 01/0", {done, ready}, rdata); end
    rst_n = 1'b1; mem_ack = 1'b0;
    step();
    vectors++; if ({done, ready} !== 2'b01) begin miscompares++; $display("FAIL rst_release: got %b want 01", {done, ready}); end
    req = 1'b1; addr = 32'h24; mem_rdata = 32'hA5A5_5A5A; mem_ack = 1'b1;
    step();
    req = 1'b0;
    step();
    mem_ack = 1'b0;
    vectors++; if ({done, rdata} !== {1'b1, 32'hA5A55A5A}) begin miscompares++; $display("FAIL rst_next: got %b/%h want 1/a5a55a5a", done, rdata); end
    step();
  endtask

  initial begin
    last_load = 32'd0;
    test_reset();
    test_lbu();
    test_lh_delayed();
    test_sb();
    test_mix();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_controller.md
LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum number of cycles to wait for I_mem_ack before flagging a bus error (range 1..255).
REQ-002 SHALL have ports, in this order:
- I_clk, in, 1: the single clock, rising edge.
- I_rst_n, in, 1: asynchronous, active-low reset.
REQ-003 SHALL have CPU-side ports:
- I_req, in, 1: access request.
- I_we, in, 1: 1 = store, 0 = load.
- I_funct3, in, 3: access type. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- I_addr, in, 32: byte address.
- I_wdata, in, 32: store data, right-justified.
REQ-004 SHALL have CPU-side ports:
- O_ready, out, 1: controller idle, can accept a request.
- O_done, out, 1: one-cycle completion pulse.
- O_rdata, out, 32: extended load result.
- O_misaligned, out, 1: alignment fault pulse.
- O_buserr, out, 1: timeout fault pulse.
REQ-005 SHALL have memory-side ports:
- O_mem_req, out, 1: memory request.
- O_mem_we, out, 1: memory write enable.
- O_mem_be, out, 4: byte enables.
- O_mem_addr, out, 32: word address, bits [1:0] = 00.
- O_mem_wdata, out, 32: lane-replicated store data.
- I_mem_ack, in, 1: memory acknowledge.
- I_mem_rdata, in, 32: memory read data.

Function
REQ-006 SHALL implement a 4-state FSM:
- IDLE -> ACCESS on accepted request.
- IDLE -> FAULT on misaligned request.
- ACCESS -> RESP on I_mem_ack.
- ACCESS -> FAULT on timeout.
- RESP -> IDLE and FAULT -> IDLE unconditionally.
REQ-007 SHALL assert O_ready only in IDLE; a request is accepted when I_req and O_ready are both 1; I_req in any other state is ignored.
REQ-008 SHALL register I_we, I_funct3, I_addr and I_wdata at acceptance; later input changes SHALL NOT affect the access in flight.
REQ-009 SHALL detect misalignment at acceptance: halfword with addr[0]=1, or word with addr[1:0]!=00. Such a request SHALL go to FAULT, issue no memory request, and raise O_misaligned and O_done together for one cycle, the cycle after acceptance.
REQ-010 SHALL hold O_mem_req=1 throughout ACCESS and drive O_mem_we, O_mem_be, O_mem_addr and O_mem_wdata from registers, stable until ack.
REQ-011 SHALL generate byte enables:
- byte: 4'b0001 << addr[1:0].
- half: 4'b0011 << addr[1:0].
- word: 4'b1111.
- Loads use the same enables.
REQ-012 SHALL replicate store data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
REQ-013 SHALL process loads at ack: shift I_mem_rdata right by 8*addr[1:0], then extend:
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes through.
- Undefined funct3 is treated as LW.
REQ-014 SHALL register the load result at ack and present it on O_rdata during RESP with O_done=1. O_rdata SHALL hold its value until the next load completes. Stores SHALL leave O_rdata unchanged.
REQ-015 Latency: acceptance at cycle 0, O_mem_req=1 from cycle 1, ack at cycle k>=1, O_done at cycle k+1; minimum two cycles from acceptance to done.
REQ-016 SHALL count ACCESS cycles in an 8-bit counter cleared on entry. If the count reaches TIMEOUT without ack, the FSM SHALL drop O_mem_req, enter FAULT, and pulse O_buserr with O_done.
REQ-017 An ack arriving on the cycle the count reaches TIMEOUT SHALL win: the access completes normally and no bus error is raised.
REQ-018 SHALL ignore I_mem_ack outside ACCESS.
REQ-019 O_done, O_misaligned and O_buserr SHALL each be high for exactly one cycle per request; O_misaligned and O_buserr SHALL never be high together.

Reset
REQ-020 On I_rst_n=0 SHALL asynchronously:
- Enter IDLE.
- Force O_ready=1.
- Clear O_mem_req, O_mem_we, O_mem_be, O_mem_addr, O_mem_wdata, O_rdata, O_done, O_misaligned, O_buserr, the counter and all captured registers to 0.
REQ-021 Reset during ACCESS SHALL drop O_mem_req immediately (no clock edge required); the aborted access SHALL produce no O_done.

Structure
REQ-022 SHALL place shared constants in a package/header: load and store funct3 codes, FSM state encodings, and the byte-enable patterns.
REQ-023 SHALL put the shift-and-extend datapath in a combinational sub-module named load_align (inputs: rdata, addr[1:0], funct3; output: 32-bit result).

Verification
REQ-024 LBU, addr 0x103, rdata 0xAB000000, ack same cycle as req:
- O_mem_be=1000, O_mem_addr=0x100.
- O_rdata=0x000000AB at cycle 2.
REQ-025 LH, addr 0x202, rdata 0x80010000, ack delayed 5 cycles:
- O_mem_be=1100.
- O_rdata=0xFFFF8001 one cycle after ack.
REQ-026 SB, addr 0x301, wdata 0x123456C3:
- O_mem_wdata=0xC3C3C3C3, O_mem_be=0010, O_mem_we=1.
- O_rdata unchanged.
REQ-027 LW at 0x402:
- O_misaligned=1 and O_done=1 at cycle 1.
- O_mem_req never asserted.
REQ-028 LW with TIMEOUT=4 and no ack:
- O_buserr pulse after 4 ACCESS cycles.
- Repeat with ack on the 4th cycle: normal completion, no O_buserr.
REQ-029 Assert I_rst_n=0 mid-ACCESS:
- O_mem_req=0 within the same cycle.
- No O_done.
- After release: O_ready=1 and the next request completes normally.
